// File: rtl/stream_xbar_credit_ctrl.sv
// Credit-based admission in front of the stream crossbar: each input reserves one credit of its
// target output before presenting valid. Define STREAM_XBAR_CREDIT_ERR_EN for the sticky err_o and overflow checks.
module stream_xbar_credit_ctrl #(
    parameter int NumInp     = 2,
    parameter int NumOut     = 2,
    parameter int MaxCredits = 4,
    parameter int SelWidth   = (NumOut > 1) ? $clog2(NumOut) : 1,
    parameter int CntWidth   = $clog2(MaxCredits + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumInp-1:0]            inp_valid_i,
    output logic [NumInp-1:0]            inp_ready_o,
    input  logic [NumInp*SelWidth-1:0]   inp_sel_i,
    output logic [NumInp-1:0]            xbar_valid_o,
    input  logic [NumInp-1:0]            xbar_ready_i,
    input  logic [NumOut-1:0]            credit_return_i,
    output logic [NumOut*CntWidth-1:0]   credit_cnt_o,
    output logic                         err_o
);

    localparam int RrWidth = (NumInp > 1) ? $clog2(NumInp) : 1;
    localparam logic [SelWidth:0] NumOutExt = (SelWidth + 1)'(NumOut);
    localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxCredits);

    typedef enum logic {S_IDLE = 1'b0, S_RESV = 1'b1} state_e;

    state_e              r_state     [NumInp];
    state_e              w_state_nxt [NumInp];
    logic [CntWidth-1:0] r_cnt       [NumOut];
    logic [CntWidth-1:0] w_cnt_nxt   [NumOut];
    logic [RrWidth-1:0]  r_rr        [NumOut];
    logic [RrWidth-1:0]  w_rr_nxt    [NumOut];
    logic [SelWidth-1:0] w_sel       [NumInp];
    logic [NumInp-1:0]   w_mask      [NumOut];
    logic [RrWidth:0]    w_pick      [NumOut];
    logic [NumInp-1:0]   w_req;
    logic [NumInp-1:0]   w_grant_inp;
    logic [NumOut-1:0]   w_grant_out;

    // Returns {found, index} of the first set mask bit at or after start, wrapping.
    function automatic logic [RrWidth:0] rr_pick(input logic [NumInp-1:0] mask,
                                                 input logic [RrWidth-1:0] start);
        logic               found;
        logic [RrWidth-1:0] idx;
        int                 cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NumInp; k++) begin
            cand = (int'(start) + k) % NumInp;
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = RrWidth'(cand);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [RrWidth-1:0] rr_inc(input logic [RrWidth-1:0] idx);
        logic [RrWidth-1:0] res;
        if (int'(idx) >= NumInp - 1) res = '0;
        else                         res = idx + RrWidth'(1);
        return res;
    endfunction

    // Saturating credit update; a take only happens when cnt > 0, so no underflow path.
    function automatic logic [CntWidth-1:0] sat_credit(input logic [CntWidth-1:0] cnt,
                                                       input logic take,
                                                       input logic give);
        logic [CntWidth-1:0] res;
        res = cnt;
        if (take && !give)                       res = cnt - CntWidth'(1);
        else if (give && !take && cnt != CntMax) res = cnt + CntWidth'(1);
        return res;
    endfunction

    always_comb begin
        w_req = '0;
        for (int i = 0; i < NumInp; i++) begin
            w_sel[i] = inp_sel_i[i*SelWidth +: SelWidth];
            w_req[i] = (r_state[i] == S_IDLE) && inp_valid_i[i] && ({1'b0, w_sel[i]} < NumOutExt);
        end
    end

    always_comb begin
        for (int j = 0; j < NumOut; j++) begin
            w_mask[j] = '0;
            for (int i = 0; i < NumInp; i++) begin
                w_mask[j][i] = w_req[i] && (w_sel[i] == SelWidth'(j));
            end
        end
    end

    // One grant per output per cycle, gated by the registered credit count only.
    always_comb begin
        w_grant_inp = '0;
        w_grant_out = '0;
        for (int j = 0; j < NumOut; j++) begin
            w_rr_nxt[j] = r_rr[j];
            w_pick[j]   = rr_pick(w_mask[j], r_rr[j]);
            if (w_pick[j][RrWidth] && (r_cnt[j] != '0)) begin
                w_grant_out[j]                       = 1'b1;
                w_grant_inp[w_pick[j][RrWidth-1:0]] = 1'b1;
                w_rr_nxt[j]                          = rr_inc(w_pick[j][RrWidth-1:0]);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NumOut; j++) begin
            w_cnt_nxt[j] = sat_credit(r_cnt[j], w_grant_out[j], credit_return_i[j]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int j = 0; j < NumOut; j++) begin
                r_cnt[j] <= CntMax;
                r_rr[j]  <= '0;
            end
        end else begin
            for (int j = 0; j < NumOut; j++) begin
                r_cnt[j] <= w_cnt_nxt[j];
                r_rr[j]  <= w_rr_nxt[j];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumInp; i++) r_state[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < NumInp; i++) r_state[i] <= w_state_nxt[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NumInp; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                S_IDLE:  if (w_grant_inp[i])  w_state_nxt[i] = S_RESV;
                S_RESV:  if (xbar_ready_i[i]) w_state_nxt[i] = S_IDLE;
                default: w_state_nxt[i] = S_IDLE;
            endcase
        end
    end

    // Valid is held purely by the reservation state, so it cannot drop before a handshake.
    always_comb begin
        xbar_valid_o = '0;
        inp_ready_o  = '0;
        for (int i = 0; i < NumInp; i++) begin
            xbar_valid_o[i] = (r_state[i] == S_RESV);
            inp_ready_o[i]  = (r_state[i] == S_RESV) && xbar_ready_i[i];
        end
    end

    always_comb begin
        credit_cnt_o = '0;
        for (int j = 0; j < NumOut; j++) begin
            credit_cnt_o[j*CntWidth +: CntWidth] = r_cnt[j];
        end
    end

`ifdef STREAM_XBAR_CREDIT_ERR_EN
    logic [NumOut-1:0] w_ovf;
    logic              r_err;

    always_comb begin
        w_ovf = '0;
        for (int j = 0; j < NumOut; j++) begin
            w_ovf[j] = credit_return_i[j] && !w_grant_out[j] && (r_cnt[j] == CntMax);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)       r_err <= 1'b0;
        else if (|w_ovf) r_err <= 1'b1;
    end

    assign err_o = r_err;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int j = 0; j < NumOut; j++) begin
                assert (!w_ovf[j]) else $warning("credit overflow on output %0d", j);
            end
            for (int i = 0; i < NumInp; i++) begin
                assert (!((r_state[i] == S_RESV) && !inp_valid_i[i] && !xbar_ready_i[i]))
                    else $error("input %0d dropped valid while reserved", i);
            end
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_stream_xbar_credit_ctrl.sv
// Bench for stream_xbar_credit_ctrl: directed vector table, out-of-range select on a 3-output
// instance, then randomized traffic against a queue-free behavioural credit model.
module tb_stream_xbar_credit_ctrl;

    localparam int NI = 2;
    localparam int NO = 2;
    localparam int MC = 4;
    localparam int CW = 3;
`ifdef STREAM_XBAR_CREDIT_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] vld = '0, sel = '0, xr = '0, ret = '0;
    logic [1:0] rdy, xv;
    logic [5:0] cnt;
    logic       err;

    logic [1:0] vld3 = '0, xr3 = '0;
    logic [3:0] sel3 = '0;
    logic [2:0] ret3 = '0;
    logic [1:0] rdy3, xv3;
    logic [8:0] cnt3;
    logic       err3;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    stream_xbar_credit_ctrl #(.NumInp(2), .NumOut(2), .MaxCredits(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .inp_valid_i(vld), .inp_ready_o(rdy), .inp_sel_i(sel),
        .xbar_valid_o(xv), .xbar_ready_i(xr),
        .credit_return_i(ret), .credit_cnt_o(cnt), .err_o(err)
    );

    stream_xbar_credit_ctrl #(.NumInp(2), .NumOut(3), .MaxCredits(4)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .inp_valid_i(vld3), .inp_ready_o(rdy3), .inp_sel_i(sel3),
        .xbar_valid_o(xv3), .xbar_ready_i(xr3),
        .credit_return_i(ret3), .credit_cnt_o(cnt3), .err_o(err3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] vld, sel, xr, ret;
        logic [1:0] xv, rdy;
        int         c0, c1;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic r, input logic [1:0] v, input logic [1:0] s, input logic [1:0] x,
                       input logic [1:0] rt, input logic [1:0] exv, input logic [1:0] erd,
                       input int c0, input int c1, input logic e);
        vec_t t;
        t.rst = r; t.vld = v; t.sel = s; t.xr = x; t.ret = rt;
        t.xv = exv; t.rdy = erd; t.c0 = c0; t.c1 = c1; t.err = e;
        tbl.push_back(t);
    endtask

    // Behavioural model: reservation flag, free credits and round-robin start per output.
    bit m_resv[NI];
    int m_cnt[NO];
    int m_rr[NO];
    bit m_err;
    bit pend[NI];
    int psel[NI];

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin m_resv[i] = 0; pend[i] = 0; psel[i] = 0; end
        for (int j = 0; j < NO; j++) begin m_cnt[j] = MC; m_rr[j] = 0; end
        m_err = 0;
    endtask

    task automatic model_step();
        bit won[NI];
        int used[NO];
        int idx;
        int n;
        for (int i = 0; i < NI; i++) won[i] = 0;
        for (int j = 0; j < NO; j++) begin
            used[j] = 0;
            if (m_cnt[j] > 0) begin
                for (int k = 0; k < NI; k++) begin
                    idx = (m_rr[j] + k) % NI;
                    if (!m_resv[idx] && vld[idx] && int'(sel[idx]) == j) begin
                        won[idx] = 1;
                        used[j]  = 1;
                        m_rr[j]  = (idx + 1) % NI;
                        break;
                    end
                end
            end
        end
        for (int j = 0; j < NO; j++) begin
            n = m_cnt[j] - used[j] + int'(ret[j]);
            if (n > MC) begin n = MC; m_err = 1; end
            m_cnt[j] = n;
        end
        for (int i = 0; i < NI; i++) begin
            if (m_resv[i]) m_resv[i] = !xr[i];
            else           m_resv[i] = won[i];
        end
    endtask

    initial begin
        // rst vld  sel  xr   ret   xv   rdy  c0 c1 err
        row(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 4, 4, 0);
        row(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 4, 3, 0);
        row(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 4, 3, 0);
        row(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 4, 2, 0);
        row(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 4, 2, 0);
        row(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 4, 1, 0);
        row(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 4, 1, 0);
        row(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 4, 0, 0);
        row(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 4, 0, 0);
        row(0, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 4, 0, 0);
        row(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 4, 1, 0);
        row(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 4, 0, 0);
        row(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4, 0, 0);
        // both inputs contend for output 0
        row(0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 4, 0, 0);
        row(0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 2'b01, 3, 0, 0);
        row(0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 2'b10, 2, 0, 0);
        row(0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 2'b01, 1, 0, 0);
        row(0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 2'b10, 0, 0, 0);
        row(0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0);
        row(0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1, 0, 0);
        // grant and return together, then reset mid-reservation
        row(0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2, 0, 0);
        row(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2, 0, 0);
        row(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2, 0, 0);
        row(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4, 4, 0);
        row(0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 4, 4, 0);
        row(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4, 4, 1);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[n]) begin
            rst = tbl[n].rst; vld = tbl[n].vld; sel = tbl[n].sel;
            xr = tbl[n].xr; ret = tbl[n].ret;
            @(negedge clk);
            chk($sformatf("row%0d xbar_valid", n), 32'(xv), 32'(tbl[n].xv));
            chk($sformatf("row%0d inp_ready", n), 32'(rdy), 32'(tbl[n].rdy));
            chk($sformatf("row%0d cnt0", n), 32'(cnt[2:0]), 32'(tbl[n].c0));
            chk($sformatf("row%0d cnt1", n), 32'(cnt[5:3]), 32'(tbl[n].c1));
            chk($sformatf("row%0d err", n), 32'(err), 32'(tbl[n].err & ErrEn));
            @(posedge clk);
            #1;
        end
        vld = '0; ret = '0; xr = '0; rst = 1'b0;

        // out-of-range select (3 on a 3-output instance) must never be granted
        vld3 = 2'b01; sel3 = 4'b0011; xr3 = 2'b11;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("oor xbar_valid", 32'(xv3), 32'd0);
            chk("oor inp_ready", 32'(rdy3), 32'd0);
            chk("oor cnt", 32'(cnt3), 32'(9'b100_100_100));
            @(posedge clk);
            #1;
        end
        vld3 = 2'b11; sel3 = 4'b1011; xr3 = 2'b00;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("oor neighbour xbar_valid", 32'(xv3), 32'(2'b10));
        chk("oor neighbour cnt", 32'(cnt3), 32'(9'b011_100_100));
        chk("oor err", 32'(err3), 32'd0);
        vld3 = '0; xr3 = '0;

        // randomized traffic against the model
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    pend[i] = 1;
                    psel[i] = $urandom_range(0, NO - 1);
                end
                vld[i] = pend[i];
                sel[i] = psel[i][0];
                xr[i]  = $urandom_range(0, 1) != 0;
            end
            for (int j = 0; j < NO; j++) ret[j] = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("rnd c%0d xbar_valid%0d", c, i), 32'(xv[i]), 32'(m_resv[i]));
                chk($sformatf("rnd c%0d inp_ready%0d", c, i), 32'(rdy[i]), 32'(m_resv[i] & xr[i]));
            end
            for (int j = 0; j < NO; j++) begin
                chk($sformatf("rnd c%0d cnt%0d", c, j), 32'(cnt[j*CW +: CW]), 32'(m_cnt[j]));
            end
            chk($sformatf("rnd c%0d err", c), 32'(err), 32'(m_err & ErrEn));
            for (int i = 0; i < NI; i++) if (m_resv[i] && xr[i]) pend[i] = 0;
            model_step();
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
